// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 4-bit registered arithmetic/logic unit with NZCV status flags.
//
// Operands, opcode and carry-in are sampled on every rising clk edge. Result
// and flags are registered, so they appear one cycle later. There is no path
// from the inputs to the outputs that bypasses the registers.
//
// Handshake: none. A new operation is accepted on every edge and Y/NZCV always
// hold the result of the operation sampled on the previous edge (or zero after
// a reset edge).
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous reset, active-low (0 = reset)
//   A       in   4  operand A
//   B       in   4  operand B
//   OPCODE  in   4  operation select
//   Cin     in   1  carry-in, used only by ADC and SBC
//   Y       out  4  registered result
//   N       out  1  negative flag (Y[3])
//   Z       out  1  zero flag (Y == 0)
//   C       out  1  carry / no-borrow / shifted-out bit
//   V       out  1  signed overflow
// ---------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] OPCODE,
  input  logic       Cin,
  output logic [3:0] Y,
  output logic       N,
  output logic       Z,
  output logic       C,
  output logic       V
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADC = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_DEC = 4'b0101;
  localparam logic [3:0] OP_NEG = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_LSL = 4'b1011;
  localparam logic [3:0] OP_LSR = 4'b1100;
  localparam logic [3:0] OP_ASR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  // All arithmetic ops share one adder: sum = x_op + y_op + ci.
  logic [3:0] x_op;
  logic [3:0] y_op;
  logic       ci;
  logic       arith;
  logic [4:0] sum;
  logic [3:0] res;
  logic       c_nxt;
  logic       v_nxt;

  always_comb begin
    x_op  = A;
    y_op  = B;
    ci    = 1'b0;
    arith = 1'b0;
    res   = 4'b0000;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    sum   = 5'b00000;

    unique case (OPCODE)
      OP_ADD: begin arith = 1'b1; end
      OP_ADC: begin arith = 1'b1; ci = Cin; end
      OP_SUB: begin arith = 1'b1; y_op = ~B; ci = 1'b1; end
      OP_SBC: begin arith = 1'b1; y_op = ~B; ci = Cin; end
      OP_INC: begin arith = 1'b1; y_op = 4'b0000; ci = 1'b1; end
      OP_DEC: begin arith = 1'b1; y_op = 4'b1111; end
      // NEG is 0 - A, done as 0 + ~A + 1 so the flags follow the adder rules.
      OP_NEG: begin arith = 1'b1; x_op = 4'b0000; y_op = ~A; ci = 1'b1; end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      OP_LSL: begin res = {A[2:0], 1'b0}; c_nxt = A[3]; end
      OP_LSR: begin res = {1'b0, A[3:1]}; c_nxt = A[0]; end
      OP_ASR: begin res = {A[3], A[3:1]}; c_nxt = A[0]; end
      OP_ROL: begin res = {A[2:0], A[3]}; c_nxt = A[3]; end
      OP_ROR: begin res = {A[0], A[3:1]}; c_nxt = A[0]; end
      default: res = 4'b0000;
    endcase

    sum = {1'b0, x_op} + {1'b0, y_op} + {4'b0000, ci};
    if (arith) begin
      res   = sum[3:0];
      // Carry out doubles as "no borrow" for the subtract forms.
      c_nxt = sum[4];
      // Overflow: both addends share a sign and the result sign differs.
      v_nxt = (x_op[3] == y_op[3]) && (sum[3] != x_op[3]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      Y <= 4'b0000;
      N <= 1'b0;
      Z <= 1'b0;
      C <= 1'b0;
      V <= 1'b0;
    end else begin
      Y <= res;
      N <= res[3];
      Z <= (res == 4'b0000);
      C <= c_nxt;
      V <= v_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// Driver applies one operation per cycle on the falling edge and pushes the
// expected {Y,N,Z,C,V} into exp_q; the monitor pops and compares just after
// each rising edge. Directed vectors carry hand-derived expectations; random
// vectors use an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] OPCODE;
  logic       Cin;
  logic [3:0] Y;
  logic       N;
  logic       Z;
  logic       C;
  logic       V;

  logic [7:0] exp_q[$];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  bit         drive_done = 1'b0;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .OPCODE (OPCODE),
    .Cin    (Cin),
    .Y      (Y),
    .N      (N),
    .Z      (Z),
    .C      (C),
    .V      (V)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int sgn(int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic logic [7:0] model(int a, int b, int op, int cin);
    int r, s, bw;
    bit c, v;
    logic [3:0] la, lb;
    la = 4'(a);
    lb = 4'(b);
    r = 0; s = 0; c = 0; v = 0;
    case (op)
      0:  begin r = (a + b) % 16;       c = (a + b) > 15;       s = sgn(a) + sgn(b); end
      1:  begin r = (a + b + cin) % 16; c = (a + b + cin) > 15; s = sgn(a) + sgn(b) + cin; end
      2:  begin r = (a - b + 16) % 16;  c = (a >= b);           s = sgn(a) - sgn(b); end
      3:  begin
            bw = 1 - cin;
            r  = (a - b - bw + 32) % 16;
            c  = (a >= b + bw);
            s  = sgn(a) - sgn(b) - bw;
          end
      4:  begin r = (a + 1) % 16;  c = (a == 15); s = sgn(a) + 1; end
      5:  begin r = (a + 15) % 16; c = (a != 0);  s = sgn(a) - 1; end
      6:  begin r = (16 - a) % 16; c = (a == 0);  s = -sgn(a); end
      7:  r = int'(la & lb);
      8:  r = int'(la | lb);
      9:  r = int'(la ^ lb);
      10: r = 15 - a;
      11: begin r = (a * 2) % 16;           c = (a >= 8); end
      12: begin r = a / 2;                  c = (a % 2) == 1; end
      13: begin r = a / 2 + ((a >= 8) ? 8 : 0); c = (a % 2) == 1; end
      14: begin r = (a * 2) % 16 + a / 8;   c = (a >= 8); end
      default: begin r = a / 2 + (a % 2) * 8; c = (a % 2) == 1; end
    endcase
    if (op <= 6) v = (s > 7) || (s < -8);
    return {4'(r), (r >= 8), (r == 0), c, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic ci, input logic [7:0] exp);
    @(negedge clk);
    rst = r; A = a; B = b; OPCODE = op; Cin = ci;
    exp_q.push_back(exp);
  endtask

  task automatic drive_rand();
    logic r;
    logic [3:0] a, b, op;
    logic ci;
    r  = ($urandom_range(0, 19) != 0);
    a  = 4'($urandom_range(0, 15));
    b  = 4'($urandom_range(0, 15));
    op = 4'($urandom_range(0, 15));
    ci = 1'($urandom_range(0, 1));
    drive(r, a, b, op, ci, r ? model(a, b, op, ci) : 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; A = 4'h0; B = 4'h0; OPCODE = 4'h0; Cin = 1'b0;
    // Reset with junk inputs: outputs must be zero.
    drive(1'b0, 4'h7, 4'h9, 4'h0, 1'b1, {4'h0, 4'b0000});
    // Directed vectors, expectations written out as {Y, N,Z,C,V}.
    drive(1'b1, 4'h2, 4'h3, 4'h0, 1'b0, {4'h5, 4'b0000}); // ADD
    drive(1'b1, 4'h7, 4'h1, 4'h0, 1'b0, {4'h8, 4'b1001}); // ADD ovf
    drive(1'b1, 4'hF, 4'h1, 4'h0, 1'b1, {4'h0, 4'b0110}); // ADD carry, Cin ignored
    drive(1'b1, 4'h8, 4'h8, 4'h1, 1'b1, {4'h1, 4'b0011}); // ADC
    drive(1'b1, 4'h8, 4'h8, 4'h1, 1'b0, {4'h0, 4'b0111}); // ADC
    drive(1'b1, 4'h3, 4'h5, 4'h2, 1'b0, {4'hE, 4'b1000}); // SUB borrow
    drive(1'b1, 4'h5, 4'h5, 4'h2, 1'b0, {4'h0, 4'b0110}); // SUB equal
    drive(1'b1, 4'h5, 4'h2, 4'h3, 1'b0, {4'h2, 4'b0010}); // SBC
    drive(1'b1, 4'h8, 4'h0, 4'h6, 1'b0, {4'h8, 4'b1001}); // NEG -8
    drive(1'b1, 4'hC, 4'hA, 4'h7, 1'b0, {4'h8, 4'b1000}); // AND
    drive(1'b1, 4'hF, 4'hF, 4'h9, 1'b0, {4'h0, 4'b0100}); // XOR
    drive(1'b1, 4'h0, 4'h0, 4'hA, 1'b0, {4'hF, 4'b1000}); // NOT
    drive(1'b1, 4'h9, 4'h0, 4'hB, 1'b0, {4'h2, 4'b0010}); // LSL
    drive(1'b1, 4'h8, 4'h0, 4'hD, 1'b0, {4'hC, 4'b1000}); // ASR
    drive(1'b1, 4'h1, 4'h0, 4'hF, 1'b0, {4'h8, 4'b1010}); // ROR
    drive(1'b1, 4'h1, 4'h0, 4'hC, 1'b0, {4'h0, 4'b0110}); // LSR
    drive(1'b1, 4'hF, 4'h0, 4'h4, 1'b0, {4'h0, 4'b0110}); // INC wrap
    drive(1'b1, 4'h0, 4'h0, 4'h5, 1'b1, {4'hF, 4'b1000}); // DEC borrow
    drive(1'b1, 4'h8, 4'h0, 4'h5, 1'b0, {4'h7, 4'b0011}); // DEC ovf
    drive(1'b1, 4'h9, 4'h0, 4'hE, 1'b0, {4'h3, 4'b0010}); // ROL
    // Mid-stream reset overrides an op, then the next op is visible at once.
    drive(1'b0, 4'hF, 4'hF, 4'h8, 1'b0, {4'h0, 4'b0000});
    drive(1'b1, 4'hA, 4'h5, 4'h8, 1'b0, {4'hF, 4'b1000}); // OR
    for (int i = 0; i < 400; i++) drive_rand();
    drive_done = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [7:0] exp, act;
      exp = exp_q.pop_front();
      act = {Y, N, Z, C, V};
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL alu_out #%0d: got Y=%h NZCV=%b, expected Y=%h NZCV=%b",
                    chk_cnt, act[7:4], act[3:0], exp[7:4], exp[3:0]);
    end
  end

  // ---------------- final report ----------------
  initial begin
    int guard;
    guard = 0;
    while (!drive_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    if (!drive_done || exp_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
